// File: rtl/div_unit_pkg.sv
// Shared constants for the EX-stage iterative divider: state encodings and default width.
package div_unit_pkg;
  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;
endpackage

// File: rtl/div_unit_abs_neg.sv
// Conditional two's-complement negate, used both for operand magnitudes and
// for sign correction of the quotient/remainder.
module div_abs_neg
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             neg_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Negate when requested; the carry out of the MSB is dropped.
  always_comb begin
    dout = din;
    if (neg_en) begin
      dout = ~din + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX; quotient goes to LO,
// remainder to HI, and div_stop holds EX until the result is ready.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             es_valid,
  input  logic             div_op,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_x,
  input  logic [WIDTH-1:0] div_y,
  input  logic             es_allowin,
  input  logic             es_flush,
  output logic             div_stop,
  output logic             div_done,
  output logic [WIDTH-1:0] div_q,
  output logic [WIDTH-1:0] div_r
);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] x_raw_r;
  logic             sign_q_r;
  logic             sign_r_r;
  logic             y_zero_r;
  logic             div_done_r;
  logic [WIDTH-1:0] div_q_r;
  logic [WIDTH-1:0] div_r_r;

  logic             req_s;
  logic             abort_s;
  logic             start_s;
  logic             last_s;
  logic [WIDTH-1:0] abs_x_s;
  logic [WIDTH-1:0] abs_y_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] rem_nxt_s;
  logic [WIDTH-1:0] quo_nxt_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;

  assign req_s    = es_valid & div_op & ~es_flush;
  // Losing the EX instruction mid-divide is handled exactly like a flush.
  assign abort_s  = es_flush | ~es_valid;
  assign start_s  = (state_r == DIV_IDLE) & req_s;
  assign last_s   = (state_r == DIV_BUSY) & (cnt_r == CNT_W'(WIDTH - 1));
  assign div_stop = req_s & (state_r != DIV_DONE);

  assign div_done = div_done_r;
  assign div_q    = div_q_r;
  assign div_r    = div_r_r;

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_x (
    .neg_en (div_signed & div_x[WIDTH-1]),
    .din    (div_x),
    .dout   (abs_x_s)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_y (
    .neg_en (div_signed & div_y[WIDTH-1]),
    .din    (div_y),
    .dout   (abs_y_s)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_fix_q (
    .neg_en (sign_q_r),
    .din    (quo_nxt_s),
    .dout   (q_fix_s)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_fix_r (
    .neg_en (sign_r_r),
    .din    (rem_nxt_s),
    .dout   (r_fix_s)
  );

  // One restoring step: trial-subtract the divisor from the shifted partial remainder.
  always_comb begin
    diff_s    = {rem_r, quo_r[WIDTH-1]} - {1'b0, dvs_r};
    quo_nxt_s = {quo_r[WIDTH-2:0], ~diff_s[WIDTH]};
    rem_nxt_s = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
    if (!diff_s[WIDTH]) begin
      rem_nxt_s = diff_s[WIDTH-1:0];
    end else begin
      rem_nxt_s = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
    end
  end

  // Next-state selection for IDLE/BUSY/DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      DIV_IDLE: begin
        if (req_s) begin
          state_nxt_s = DIV_BUSY;
        end else begin
          state_nxt_s = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        if (abort_s) begin
          state_nxt_s = DIV_IDLE;
        end else if (last_s) begin
          state_nxt_s = DIV_DONE;
        end else begin
          state_nxt_s = DIV_BUSY;
        end
      end
      DIV_DONE: begin
        // No restart while waiting here, even though div_op is still high.
        if (abort_s || es_allowin) begin
          state_nxt_s = DIV_IDLE;
        end else begin
          state_nxt_s = DIV_DONE;
        end
      end
      default: state_nxt_s = DIV_IDLE;
    endcase
  end

  // State, done flag and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= DIV_IDLE;
      div_done_r <= 1'b0;
      div_q_r    <= {WIDTH{1'b0}};
      div_r_r    <= {WIDTH{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      div_done_r <= (state_nxt_s == DIV_DONE);
      if (last_s && !abort_s) begin
        div_q_r <= y_zero_r ? {WIDTH{1'b1}} : q_fix_s;
        div_r_r <= y_zero_r ? x_raw_r : r_fix_s;
      end
    end
  end

  // Operand capture on acceptance, then one quotient bit per BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= {CNT_W{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      x_raw_r  <= {WIDTH{1'b0}};
      sign_q_r <= 1'b0;
      sign_r_r <= 1'b0;
      y_zero_r <= 1'b0;
    end else if (start_s) begin
      cnt_r    <= {CNT_W{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= abs_x_s;
      dvs_r    <= abs_y_s;
      x_raw_r  <= div_x;
      sign_q_r <= div_signed & (div_x[WIDTH-1] ^ div_y[WIDTH-1]);
      sign_r_r <= div_signed & div_x[WIDTH-1];
      y_zero_r <= (div_y == {WIDTH{1'b0}});
    end else if (state_r == DIV_BUSY) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      rem_r <= rem_nxt_s;
      quo_r <= quo_nxt_s;
    end
  end

endmodule
